// File: rtl/dpram_wr_arbiter_if.sv
// Write-side bundle between the ADC/CPU requesters and the DPRAM port-2 write arbiter.
// master = requester side (ADC stream, CPU/CSR), slave = the arbiter.
interface dpram_wr_arbiter_if #(
    parameter int AW         = 13,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    logic          adc_we_i;
    logic [AW-1:0] adc_addr_i;
    logic [DW-1:0] adc_data_i;
    logic          cpu_req_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_data_i;
    logic          cpu_gnt_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic          ovf_clr_i;
    logic          adc_ovf_o;
    logic [LW-1:0] fifo_level_o;

    modport master (
        output adc_we_i, adc_addr_i, adc_data_i,
        output cpu_req_i, cpu_addr_i, cpu_data_i,
        output ovf_clr_i,
        input  cpu_gnt_o, ram_we_o, ram_addr_o, ram_data_o,
        input  adc_ovf_o, fifo_level_o
    );

    modport slave (
        input  adc_we_i, adc_addr_i, adc_data_i,
        input  cpu_req_i, cpu_addr_i, cpu_data_i,
        input  ovf_clr_i,
        output cpu_gnt_o, ram_we_o, ram_addr_o, ram_data_o,
        output adc_ovf_o, fifo_level_o
    );
endinterface

// File: rtl/dpram_wr_arbiter.sv
// DPRAM write-port arbiter: buffers the non-stallable ADC stream in a small FIFO and
// inserts CPU writes, forcing a CPU slot after STARVE_MAX denied cycles.
module dpram_wr_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    dpram_wr_arbiter_if.slave      bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_ADC  = 2'd1,
        G_CPU  = 2'd2
    } gsel_t;

    logic [AW+DW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [SW-1:0]    r_starve;
    gsel_t            r_state;
    logic             r_ovf;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_data;

    gsel_t            w_sel;
    logic             w_empty;
    logic             w_full;
    logic             w_cpu_elig;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW+DW-1:0] w_head;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    // The request is still held during the grant cycle; mask it so it is not written twice.
    assign w_cpu_elig = bus.cpu_req_i & (r_state != G_CPU);
    assign w_head     = r_mem[r_rptr];

    always_comb begin
        w_sel = G_NONE;
        if (w_cpu_elig && (r_starve == SW'(STARVE_MAX))) begin
            w_sel = G_CPU;
        end else if (!w_empty) begin
            w_sel = G_ADC;
        end else if (w_cpu_elig) begin
            w_sel = G_CPU;
        end
    end

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign w_pop  = (w_sel == G_ADC);
    assign w_push = bus.adc_we_i & (~w_full | w_pop);
    assign w_drop = bus.adc_we_i & w_full & ~w_pop;

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.adc_addr_i, bus.adc_data_i};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_starve <= '0;
            r_state  <= G_NONE;
            r_ovf    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            r_state <= w_sel;
            case (w_sel)
                G_ADC: begin
                    r_addr <= w_head[AW+DW-1:DW];
                    r_data <= w_head[DW-1:0];
                end
                G_CPU: begin
                    r_addr <= bus.cpu_addr_i;
                    r_data <= bus.cpu_data_i;
                end
                default: begin
                    r_addr <= r_addr;
                    r_data <= r_data;
                end
            endcase

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr_i) begin
                r_ovf <= 1'b0;
            end

            if ((w_sel == G_CPU) || !bus.cpu_req_i) begin
                r_starve <= '0;
            end else if (w_cpu_elig && w_pop && (r_starve != SW'(STARVE_MAX))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    assign bus.ram_we_o     = (r_state != G_NONE);
    assign bus.cpu_gnt_o    = (r_state == G_CPU);
    assign bus.ram_addr_o   = r_addr;
    assign bus.ram_data_o   = r_data;
    assign bus.adc_ovf_o    = r_ovf;
    assign bus.fifo_level_o = r_level;
endmodule

// File: tb/tb_dpram_wr_arbiter.sv
// Bench for dpram_wr_arbiter: vector table, directed starvation/overflow/reset
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_dpram_wr_arbiter;
    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    logic sys_clk;
    logic sys_rst_n;

    dpram_wr_arbiter_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

    dpram_wr_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          req;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cdata;
        logic          clr;
        logic          e_we;
        logic          e_gnt;
        logic          e_ovf;
        logic [2:0]    e_lvl;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs [8];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of pending samples plus expected port values.
    logic [AW+DW-1:0] q [$];
    logic             m_we, m_gnt, m_ovf;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    int               m_starve;
    bit               auto_adc;

    function automatic logic [63:0] pk(logic we, logic gnt, logic ovf, logic [2:0] lvl,
                                       logic [AW-1:0] a, logic [DW-1:0] d);
        return {13'd0, we, gnt, ovf, lvl, a, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_we = 0; m_gnt = 0; m_ovf = 0; m_addr = '0; m_data = '0; m_starve = 0;
    endtask

    task automatic model_eval();
        bit elig;
        bit drop;
        int sel;
        logic [AW+DW-1:0] e;
        elig = bus.cpu_req_i && !m_gnt;
        drop = 0;
        if (elig && m_starve == SMAX) sel = 2;
        else if (q.size() > 0)        sel = 1;
        else if (elig)                sel = 2;
        else                          sel = 0;
        if (sel == 1) begin
            e = q.pop_front();
            m_addr = e[AW+DW-1:DW];
            m_data = e[DW-1:0];
        end else if (sel == 2) begin
            m_addr = bus.cpu_addr_i;
            m_data = bus.cpu_data_i;
        end
        if (bus.adc_we_i) begin
            if (q.size() < DEPTH) q.push_back({bus.adc_addr_i, bus.adc_data_i});
            else drop = 1;
        end
        m_we  = (sel != 0);
        m_gnt = (sel == 2);
        if (drop) m_ovf = 1;
        else if (bus.ovf_clr_i) m_ovf = 0;
        if (sel == 2 || !bus.cpu_req_i) m_starve = 0;
        else if (elig && sel == 1 && m_starve < SMAX) m_starve++;
    endtask

    function automatic logic [63:0] dut_out();
        return pk(bus.ram_we_o, bus.cpu_gnt_o, bus.adc_ovf_o, bus.fifo_level_o,
                  bus.ram_addr_o, bus.ram_data_o);
    endfunction

    task automatic step();
        model_eval();
        @(posedge sys_clk);
        #1;
        check("cycle", dut_out(), pk(m_we, m_gnt, m_ovf, 3'(q.size()), m_addr, m_data));
        if (auto_adc) begin
            bus.adc_addr_i = bus.adc_addr_i + 13'd1;
            bus.adc_data_i = 32'hA5A5_0000 | {19'd0, bus.adc_addr_i};
        end
    endtask

    task automatic idle_inputs();
        bus.adc_we_i = 0; bus.adc_addr_i = '0; bus.adc_data_i = '0;
        bus.cpu_req_i = 0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
        bus.ovf_clr_i = 0;
        auto_adc = 0;
    endtask

    task automatic do_reset();
        sys_rst_n = 0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_state", dut_out(), 64'd0);
        sys_rst_n = 1;
    endtask

    task automatic start_adc(input logic [AW-1:0] base);
        auto_adc = 1;
        bus.adc_we_i = 1;
        bus.adc_addr_i = base;
        bus.adc_data_i = 32'hA5A5_0000 | {19'd0, base};
    endtask

    // Hold a CPU request until it is granted; returns the number of denied cycles.
    task automatic force_grant(input bit clr_hold, output int denied);
        bit got;
        got = 0;
        denied = 0;
        bus.cpu_req_i = 1;
        bus.cpu_addr_i = 13'($urandom);
        bus.cpu_data_i = $urandom;
        bus.ovf_clr_i = clr_hold;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (bus.cpu_gnt_o === 1'b1) got = 1;
            else denied++;
        end
        check("grant_seen", 64'(got), 64'd1);
        bus.cpu_req_i = 0;
        bus.ovf_clr_i = 0;
    endtask

    initial begin
        int denied;
        sys_rst_n = 0;
        idle_inputs();
        model_clear();

        //              we addr     data          req caddr    cdata          clr  we gnt ovf lvl  addr     data
        vecs[0] = '{1'b1, 13'h400, 32'h0000_00A0, 1'b0, 13'h000, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 13'h000, 32'h0};
        vecs[1] = '{1'b1, 13'h401, 32'h0000_00A1, 1'b0, 13'h000, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 13'h400, 32'hA0};
        vecs[2] = '{1'b1, 13'h402, 32'h0000_00A2, 1'b0, 13'h000, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 13'h401, 32'hA1};
        vecs[3] = '{1'b0, 13'h000, 32'h0,         1'b0, 13'h000, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 13'h402, 32'hA2};
        vecs[4] = '{1'b0, 13'h000, 32'h0,         1'b0, 13'h000, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 13'h402, 32'hA2};
        vecs[5] = '{1'b0, 13'h000, 32'h0,         1'b1, 13'h010, 32'hDEADBEEF,   1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 13'h010, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 13'h000, 32'h0,         1'b1, 13'h010, 32'hDEADBEEF,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 13'h010, 32'hDEADBEEF};
        vecs[7] = '{1'b0, 13'h000, 32'h0,         1'b0, 13'h000, 32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 13'h010, 32'hDEADBEEF};

        // ---- vector table: ADC burst latency and single CPU write ----
        do_reset();
        foreach (vecs[i]) begin
            bus.adc_we_i   = vecs[i].we;
            bus.adc_addr_i = vecs[i].addr;
            bus.adc_data_i = vecs[i].data;
            bus.cpu_req_i  = vecs[i].req;
            bus.cpu_addr_i = vecs[i].caddr;
            bus.cpu_data_i = vecs[i].cdata;
            bus.ovf_clr_i  = vecs[i].clr;
            step();
            check($sformatf("vec%0d", i), dut_out(),
                  pk(vecs[i].e_we, vecs[i].e_gnt, vecs[i].e_ovf, vecs[i].e_lvl,
                     vecs[i].e_addr, vecs[i].e_data));
        end

        // ---- starvation, then overflow on the 4th forced grant ----
        do_reset();
        start_adc(13'h400);
        repeat (4) step();
        force_grant(0, denied);
        check("starve_denials", 64'(denied), 64'(SMAX));
        check("starve_level", 64'(bus.fifo_level_o), 64'd2);
        force_grant(0, denied);
        force_grant(0, denied);
        check("pre_ovf_flag", 64'(bus.adc_ovf_o), 64'd0);
        force_grant(0, denied);
        check("ovf_set", {bus.fifo_level_o, bus.adc_ovf_o}, {3'd4, 1'b1});
        step();
        check("ovf_sticky", 64'(bus.adc_ovf_o), 64'd1);
        bus.ovf_clr_i = 1;
        step();
        bus.ovf_clr_i = 0;
        check("ovf_cleared", 64'(bus.adc_ovf_o), 64'd0);
        repeat (3) step();
        check("full_pushpop", {bus.fifo_level_o, bus.adc_ovf_o}, {3'd4, 1'b0});
        force_grant(1, denied);
        check("clr_vs_drop", 64'(bus.adc_ovf_o), 64'd1);
        step();

        // ---- reset mid-burst at level 3 ----
        do_reset();
        start_adc(13'h600);
        repeat (2) step();
        force_grant(0, denied);
        force_grant(0, denied);
        step();
        check("pre_rst_level", 64'(bus.fifo_level_o), 64'd3);
        sys_rst_n = 0;
        #1;
        check("async_rst", {bus.ram_we_o, bus.cpu_gnt_o, bus.fifo_level_o}, {1'b0, 1'b0, 3'd0});
        idle_inputs();
        model_clear();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1;
        repeat (6) step();

        // ---- randomized traffic with handshake-respecting CPU ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.adc_we_i   = ($urandom_range(0, 3) != 0);
            bus.adc_addr_i = 13'($urandom);
            bus.adc_data_i = $urandom;
            bus.ovf_clr_i  = ($urandom_range(0, 31) == 0);
            if (!bus.cpu_req_i) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.cpu_req_i  = 1;
                    bus.cpu_addr_i = 13'($urandom);
                    bus.cpu_data_i = $urandom;
                end
            end else if (m_gnt) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.cpu_req_i = 0;
                end else begin
                    bus.cpu_addr_i = 13'($urandom);
                    bus.cpu_data_i = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.cpu_req_i = 0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
